// File: rtl/boot_stream_loader_pkg.sv
// rtl/boot_stream_loader_pkg.sv - shared types and sizing helpers for the boot stream loader
// Package boot_pkg:
//   boot_state_t  loader / run-control state encoding
//   addr_bytes()  number of header bytes carrying the load address
//   len_bytes()   number of header bytes carrying the record length
package boot_pkg;

    typedef enum logic [2:0] {
        HDR_ADDR,
        HDR_LEN,
        DATA,
        RELEASE,
        RUN
    } boot_state_t;

    function automatic int addr_bytes(input int w);
        return (w + 7) / 8;
    endfunction

    function automatic int len_bytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/boot_stream_loader_irq.sv
// rtl/boot_stream_loader_irq.sv - periodic active-low soft reset pulse generator for RUN mode
// Built only when BOOT_IRQ_GEN_EN is defined.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   run          high while the loader is in RUN
//   soft_rst_n   low for WIDTH cycles every PERIOD cycles, first pulse PERIOD cycles after run rises
`ifdef BOOT_IRQ_GEN_EN
module boot_irq_pulse_gen #(
    parameter int PERIOD = 200,
    parameter int WIDTH  = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic soft_rst_n
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    // phase holds (cycles since run rose) mod PERIOD; armed marks that one full
    // period has elapsed, so the phase-0 window of the first period stays quiet
    logic [CW-1:0] phase;
    logic          armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            armed <= 1'b0;
        end else if (!run) begin
            phase <= '0;
            armed <= 1'b0;
        end else if (phase == CW'(PERIOD - 1)) begin
            phase <= '0;
            armed <= 1'b1;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign soft_rst_n = !(run && armed && (phase < CW'(WIDTH)));

endmodule
`endif

// File: rtl/boot_stream_loader.sv
// rtl/boot_stream_loader.sv - byte-stream program loader and CPU run controller
// Parses records (addr bytes, len bytes, len data bytes; len==0 terminates),
// writes data into RAM with the CPU held in reset, then releases the CPU at
// boot_pc and hands the RAM port over to it.
// Optional feature macro: BOOT_IRQ_GEN_EN (periodic cpu_soft_rst_n pulses in RUN).
// Ports:
//   clk, rst                                  clock, asynchronous active-high reset
//   ld_data, ld_valid, ld_ready               load byte stream (transfer = valid & ready)
//   reload                                    pulse in RUN to start a new load
//   cpu_mem_addr, cpu_data_out, cpu_write_en  CPU side of the RAM port
//   mem_addr, mem_data_wr, mem_write_en       RAM port (CPU in RUN, loader otherwise)
//   cpu_rst_n, cpu_soft_rst_n                 CPU reset / soft reset, active-low
//   boot_pc                                   address of first data record of this load
//   busy, done                                loading/releasing, running
module boot_stream_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int LEN_W       = 16,
    parameter int RELEASE_DLY = 10,
    parameter int IRQ_PERIOD  = 200,
    parameter int IRQ_WIDTH   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              reload,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [7:0]        cpu_data_out,
    input  logic              cpu_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data_wr,
    output logic              mem_write_en,
    output logic              cpu_rst_n,
    output logic              cpu_soft_rst_n,
    output logic [ADDR_W-1:0] boot_pc,
    output logic              busy,
    output logic              done
);

    localparam int AB  = addr_bytes(ADDR_W);
    localparam int LB  = len_bytes(LEN_W);
    localparam int ABW = AB * 8;
    localparam int LBW = LB * 8;

    boot_state_t       state;
    logic [7:0]        hdr_cnt;
    logic [ABW-1:0]    addr_sh;
    logic [LBW-1:0]    len_sh;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  len_rem;
    logic [7:0]        rel_cnt;
    logic              pc_latched;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_wdata;

    // Header fields arrive MSB first, so each byte shifts in at the bottom
    logic [ABW-1:0]    addr_nxt;
    logic [LBW-1:0]    len_nxt;
    logic [LEN_W-1:0]  len_val;

    assign addr_nxt = (addr_sh << 8) | ABW'(ld_data);
    assign len_nxt  = (len_sh << 8) | LBW'(ld_data);
    assign len_val  = LEN_W'(len_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HDR_ADDR;
            hdr_cnt    <= '0;
            addr_sh    <= '0;
            len_sh     <= '0;
            cur_addr   <= '0;
            len_rem    <= '0;
            rel_cnt    <= '0;
            pc_latched <= 1'b0;
            boot_pc    <= '0;
            ld_we      <= 1'b0;
            ld_addr    <= '0;
            ld_wdata   <= '0;
        end else begin
            ld_we <= 1'b0;
            case (state)
                HDR_ADDR: begin
                    if (ld_valid) begin
                        addr_sh <= addr_nxt;
                        if (hdr_cnt == 8'(AB - 1)) begin
                            hdr_cnt  <= '0;
                            cur_addr <= ADDR_W'(addr_nxt);
                            state    <= HDR_LEN;
                        end else begin
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end
                    end
                end
                HDR_LEN: begin
                    if (ld_valid) begin
                        len_sh <= len_nxt;
                        if (hdr_cnt == 8'(LB - 1)) begin
                            hdr_cnt <= '0;
                            if (len_val == '0) begin
                                rel_cnt <= '0;
                                state   <= RELEASE;
                            end else begin
                                len_rem <= len_val;
                                state   <= DATA;
                                // Only a record that carries data may set the boot PC,
                                // so the terminator never overwrites it.
                                if (!pc_latched) begin
                                    boot_pc    <= cur_addr;
                                    pc_latched <= 1'b1;
                                end
                            end
                        end else begin
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (ld_valid) begin
                        ld_we    <= 1'b1;
                        ld_addr  <= cur_addr;
                        ld_wdata <= ld_data;
                        cur_addr <= cur_addr + 1'b1;
                        len_rem  <= len_rem - 1'b1;
                        if (len_rem == LEN_W'(1)) begin
                            state <= HDR_ADDR;
                        end
                    end
                end
                RELEASE: begin
                    if (rel_cnt == 8'(RELEASE_DLY - 1)) begin
                        state <= RUN;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (reload) begin
                        hdr_cnt    <= '0;
                        pc_latched <= 1'b0;
                        state      <= HDR_ADDR;
                    end
                end
                default: state <= HDR_ADDR;
            endcase
        end
    end

    // Status outputs decode directly from the state register
    assign ld_ready  = (state == HDR_ADDR) || (state == HDR_LEN) || (state == DATA);
    assign done      = (state == RUN);
    assign busy      = !done;
    assign cpu_rst_n = done;

    always_comb begin
        mem_addr     = ld_addr;
        mem_data_wr  = ld_wdata;
        mem_write_en = ld_we;
        if (done) begin
            mem_addr     = cpu_mem_addr;
            mem_data_wr  = cpu_data_out;
            mem_write_en = cpu_write_en;
        end
    end

`ifdef BOOT_IRQ_GEN_EN
    boot_irq_pulse_gen #(
        .PERIOD(IRQ_PERIOD),
        .WIDTH (IRQ_WIDTH)
    ) u_irq (
        .clk       (clk),
        .rst       (rst),
        .run       (done),
        .soft_rst_n(cpu_soft_rst_n)
    );
`else
    assign cpu_soft_rst_n = 1'b1;
`endif

endmodule

// File: tb/tb_boot_stream_loader.sv
// tb/tb_boot_stream_loader.sv - self-checking bench for boot_stream_loader
module tb_boot_stream_loader;

    localparam int DLY = 10;
    localparam int PER = 200;
    localparam int WID = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        reload;
    logic [15:0] cpu_mem_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_write_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_wr;
    logic        mem_write_en;
    logic        cpu_rst_n;
    logic        cpu_soft_rst_n;
    logic [15:0] boot_pc;
    logic        busy;
    logic        done;

    boot_stream_loader #(
        .ADDR_W(16), .LEN_W(16), .RELEASE_DLY(DLY), .IRQ_PERIOD(PER), .IRQ_WIDTH(WID)
    ) dut (
        .clk(clk), .rst(rst), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .reload(reload), .cpu_mem_addr(cpu_mem_addr), .cpu_data_out(cpu_data_out),
        .cpu_write_en(cpu_write_en), .mem_addr(mem_addr), .mem_data_wr(mem_data_wr),
        .mem_write_en(mem_write_en), .cpu_rst_n(cpu_rst_n), .cpu_soft_rst_n(cpu_soft_rst_n),
        .boot_pc(boot_pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t        sb[$];
    wr_t        mon_e;
    logic [7:0] ref_mem [0:65535];
    logic [7:0] dut_ram [0:65535];
    int         wr_cnt;

    // RAM-side monitor: every loader write must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && mem_write_en && !done) begin
            wr_cnt++;
            dut_ram[mem_addr] = mem_data_wr;
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", mem_addr, mon_e.addr);
                check("wr_data", mem_data_wr, mon_e.data);
                check("wr_latency", cyc, mon_e.cyc);
            end
        end
    end

    // Reference record parser fed with each byte the bench sees accepted
    int          m_ph;
    int          m_cnt;
    logic [15:0] m_addr;
    logic [15:0] m_len;
    int          term_cyc;

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_addr = '0; m_len = '0;
    endtask

    task automatic model_accept(input logic [7:0] b, input int c);
        case (m_ph)
            0: begin
                m_addr = {m_addr[7:0], b};
                if (m_cnt == 1) begin m_cnt = 0; m_ph = 1; end else m_cnt++;
            end
            1: begin
                m_len = {m_len[7:0], b};
                if (m_cnt == 1) begin
                    m_cnt = 0;
                    if (m_len == 0) begin m_ph = 3; term_cyc = c; end else m_ph = 2;
                end else m_cnt++;
            end
            2: begin
                sb.push_back(wr_t'{addr: m_addr, data: b, cyc: c + 1});
                ref_mem[m_addr] = b;
                m_addr = m_addr + 16'd1;
                m_len  = m_len - 16'd1;
                if (m_len == 0) m_ph = 0;
            end
            default: check("byte_after_terminator", 1, 0);
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        ld_data  = b;
        ld_valid = 1'b1;
        while (!ld_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ld_ready) begin
            check("ld_ready_timeout", 0, 1);
            ld_valid = 1'b0;
        end else begin
            model_accept(b, cyc);
            @(negedge clk);
            ld_valid = 1'b0;
        end
    endtask

    task automatic wait_run();
        int t;
        t = 0;
        while (!cpu_rst_n && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("run_reached", cpu_rst_n, 1);
        check("release_delay", cyc, term_cyc + 1 + DLY);
        check("done_in_run", done, 1);
        check("busy_in_run", busy, 0);
        check("ld_ready_in_run", ld_ready, 0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_cpu_rst_n", cpu_rst_n, 0);
        check("reload_ld_ready", ld_ready, 1);
        check("reload_busy", busy, 1);
        check("reload_done", done, 0);
        model_reset();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ld_ready"}, ld_ready, 1);
        check({tag, "_mem_write_en"}, mem_write_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_data_wr"}, mem_data_wr, 0);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
        check({tag, "_cpu_soft_rst_n"}, cpu_soft_rst_n, 1);
        check({tag, "_boot_pc"}, boot_pc, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done"}, done, 0);
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [7:0]  b  [0:15];
        logic [15:0] pc;
        int          nwr;
        int          nchk;
        logic [15:0] ca [0:2];
        logic [7:0]  cd [0:2];
    } vec_t;

    vec_t tv [0:3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic       exp_soft;
        int         end_c;

        for (int i = 0; i < 65536; i++) begin
            dut_ram[i] = 8'h5A;
            ref_mem[i] = 8'h5A;
        end

        tv[0].name = "single_record";
        tv[0].n    = 11;
        tv[0].b    = '{8'h02, 8'h00, 8'h00, 8'h03, 8'hA9, 8'h05, 8'h00, 8'h00,
                       8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv[0].pc   = 16'h0200; tv[0].nwr = 3; tv[0].nchk = 3;
        tv[0].ca   = '{16'h0200, 16'h0201, 16'h0202};
        tv[0].cd   = '{8'hA9, 8'h05, 8'h00};

        tv[1].name = "two_records";
        tv[1].n    = 14;
        tv[1].b    = '{8'h03, 8'h00, 8'h00, 8'h01, 8'h11, 8'h02, 8'h00, 8'h00,
                       8'h01, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv[1].pc   = 16'h0300; tv[1].nwr = 2; tv[1].nchk = 2;
        tv[1].ca   = '{16'h0300, 16'h0200, 16'h0000};
        tv[1].cd   = '{8'h11, 8'h22, 8'h00};

        tv[2].name = "addr_wrap";
        tv[2].n    = 10;
        tv[2].b    = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h00, 8'h00,
                       8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv[2].pc   = 16'hFFFF; tv[2].nwr = 2; tv[2].nchk = 2;
        tv[2].ca   = '{16'hFFFF, 16'h0000, 16'h0000};
        tv[2].cd   = '{8'hAA, 8'hBB, 8'h00};

        tv[3].name = "terminator_only";
        tv[3].n    = 4;
        tv[3].b    = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                       8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv[3].pc   = 16'hFFFF; tv[3].nwr = 0; tv[3].nchk = 0;
        tv[3].ca   = '{16'h0000, 16'h0000, 16'h0000};
        tv[3].cd   = '{8'h00, 8'h00, 8'h00};

        rst = 1'b1; ld_data = '0; ld_valid = 1'b0; reload = 1'b0;
        cpu_mem_addr = '0; cpu_data_out = '0; cpu_write_en = 1'b0;
        wr_cnt = 0; term_cyc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table-driven loads, each followed by run entry checks
        for (int k = 0; k < 4; k++) begin
            if (k > 0) do_reload();
            wr_cnt = 0;
            for (int i = 0; i < tv[k].n; i++) begin
                send_byte(tv[k].b[i], int'($urandom_range(0, 2)));
            end
            wait_run();
            check({tv[k].name, "_boot_pc"}, boot_pc, tv[k].pc);
            check({tv[k].name, "_wr_count"}, wr_cnt, tv[k].nwr);
            check({tv[k].name, "_sb_empty"}, sb.size(), 0);
            for (int j = 0; j < tv[k].nchk; j++) begin
                check({tv[k].name, "_ram"}, dut_ram[tv[k].ca[j]], tv[k].cd[j]);
            end
        end

        // RAM port belongs to the CPU in RUN
        cpu_mem_addr = 16'h1234; cpu_data_out = 8'h77; cpu_write_en = 1'b1;
        #1;
        check("mux_addr", mem_addr, 16'h1234);
        check("mux_data", mem_data_wr, 8'h77);
        check("mux_we", mem_write_en, 1);
        cpu_write_en = 1'b0;
        #1;
        check("mux_we_low", mem_write_en, 0);
        @(negedge clk);

        // Random gaps, a 5-byte back-to-back burst, and valid held through RELEASE/RUN
        do_reload();
        wr_cnt = 0;
        send_byte(8'h10, 1); send_byte(8'h00, 0); send_byte(8'h00, 2); send_byte(8'h14, 0);
        for (int i = 0; i < 20; i++) begin
            rb = 8'($urandom);
            send_byte(rb, (i < 5) ? 0 : int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 4; i++) send_byte(8'h00, int'($urandom_range(0, 1)));
        ld_data = 8'hEE; ld_valid = 1'b1;
        wait_run();
        repeat (10) @(negedge clk);
        check("held_valid_ignored_ready", ld_ready, 0);
        ld_valid = 1'b0;
        check("gaps_wr_count", wr_cnt, 20);
        check("gaps_boot_pc", boot_pc, 16'h1000);
        for (int i = 0; i < 20; i++) begin
            check("gaps_ram", dut_ram[16'h1000 + 16'(i)], ref_mem[16'h1000 + 16'(i)]);
        end

        // Reset in the middle of a data record, then a complete new stream
        do_reload();
        send_byte(8'h40, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("midload_reset");
        sb.delete();
        model_reset();
        wr_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h05, 0); send_byte(8'h00, 1); send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'hC1, 2); send_byte(8'hC2, 0);
        check("held_before_term", cpu_rst_n, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("held_before_last", cpu_rst_n, 0);
        send_byte(8'h00, 0);
        wait_run();
        check("rst_boot_pc", boot_pc, 16'h0500);
        check("rst_wr_count", wr_cnt, 2);
        check("rst_ram0", dut_ram[16'h0500], 8'hC1);
        check("rst_ram1", dut_ram[16'h0501], 8'hC2);
        check("rst_abandoned", dut_ram[16'h4002], 8'h5A);

        // Soft reset pulses counted from the first RUN cycle (c = 0)
`ifdef BOOT_IRQ_GEN_EN
        end_c = 450;
`else
        end_c = 250;
`endif
        for (int c = 0; c <= end_c; c++) begin
`ifdef BOOT_IRQ_GEN_EN
            exp_soft = (c >= PER && c <= 300 && (c % PER) < WID) ? 1'b0 : 1'b1;
`else
            exp_soft = 1'b1;
`endif
            check("soft_rst_n", cpu_soft_rst_n, exp_soft);
`ifdef BOOT_IRQ_GEN_EN
            if (c == 300) reload = 1'b1;
            if (c == 301) begin
                reload = 1'b0;
                check("irq_reload_cpu_rst_n", cpu_rst_n, 0);
                check("irq_reload_ld_ready", ld_ready, 1);
            end
`endif
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
